rasterizer: RTL and testbench
=============================

# rasterizer

Flat-shaded triangle rasterizer for the GPU pipeline. Takes three IEEE-754 single-precision vertices, converts X/Y to integer screen coordinates, and scans the clamped bounding box one pixel per clock. It issues a framebuffer write for every pixel covered by the triangle. It sits between the command/geometry logic and `frame_buffer_top`, on the 150 MHz GPU clock.

## Interface
- `COLOR`, default 4'hF: 4-bit colour value written for every covered pixel.
- `SCREEN_W`, default 640: horizontal resolution used for clamping.
- `SCREEN_H`, default 480: vertical resolution used for clamping.

Ports:
- `clk`  in  1  GPU clock (`gpu_clk_150`).
- `areset`  in  1  Reset. Synchronous, active-high.
- `start`  in  1  Request a render. Sampled only in IDLE. May be held high.
- `p1`, `p2`, `p3`  in  3×32 each  Vertex `{x,y,z}` as IEEE-754 floats. Index 0 = x, 1 = y, 2 = z. z is ignored.
- `done`  out  1  One-cycle pulse when the triangle is finished.
- `fb_x`  out  10  Pixel column of the current write.
- `fb_y`  out  10  Pixel row of the current write.
- `data`  out  4  Pixel colour; equals `COLOR` when `fb_we` = 1.
- `fb_we`  out  1  Framebuffer write strobe, one pixel per cycle.

## Operation
States are IDLE, CONVERT, SETUP, SCAN and DONE.
- **IDLE:** if `start` = 1, latch `p1`..`p3` and go to CONVERT.
- **CONVERT:** float-to-coordinate conversion of the six x/y words, using sign, exponent `e` and mantissa `m`.
  - Negative values, or `e` < 127, give 0.
  - `e` ≥ 137 saturates to 1023.
  - Otherwise the result is `{1,m} >> (23-(e-127))`, truncated. Example: 0x428A0000 → 69.
- **SETUP:**
  - Bounding box: min/max of the vertex coordinates, clamped to [0, `SCREEN_W`-1] × [0, `SCREEN_H`-1].
  - Compute edge deltas.
  - If twice the signed area is 0 (degenerate triangle), go straight to DONE.
- **SCAN:** raster order, x fastest, from (xmin, ymin) to (xmax, ymax). Per pixel (px, py):
  - Edge function E_ab = (bx-ax)(py-ay) - (by-ay)(px-ax), for edges ab = 12, 23, 31.
  - Signed arithmetic, at least 22 bits.
  - The pixel is covered iff all three E ≥ 0 or all three E ≤ 0. This accepts either winding; edges are inclusive.
  - Covered pixels produce a write. After (xmax, ymax), go to DONE.
- **DONE:** assert `done` for one cycle, then return to IDLE.
- While `start` is held high, the rasterizer re-renders continuously.

## Timing
- Reset values: `done` = 0, `fb_we` = 0, `fb_x` = 0, `fb_y` = 0, `data` = 0, state IDLE.
- `areset` mid-operation aborts the render. No `fb_we` and no `done` appear in the cycle after the reset edge.
- Sequence after the edge that samples `start` in IDLE:
  - CONVERT occupies 1 cycle, SETUP 1 cycle.
  - SCAN then visits exactly W×H pixels, one per cycle, where W and H are the clamped bounding-box dimensions.
- All outputs are registered. The write for a pixel appears on `fb_x`, `fb_y`, `data`, `fb_we` one cycle after that pixel is evaluated.
- `done` is high exactly one cycle, the cycle after the last possible write.
- No write is ever issued with an out-of-screen coordinate.
- When `fb_we` = 0, `data` = 0 and `fb_x`/`fb_y` hold their last values.
- `start` is ignored outside IDLE.

## Structure
- Package `gpu_pkg` holds:
  - screen constants, `COORD_W` = 10;
  - the state enum;
  - an edge-function helper.
- Sub-module `float_to_coord`: combinational, 32-bit float in, 10-bit saturated unsigned out. Six instances, or one time-shared instance over CONVERT.
- FSM, bounding-box logic and scan counters live in the top level.

## Test plan
- **Right triangle** (69,69,1), (69,169,1), (169,69,1), `start` pulsed:
  - exactly 5151 writes;
  - (69,69) and (119,119) written; (120,120) and (169,169) not;
  - then one `done` pulse.
- **Opposite winding** (same vertices, p2 and p3 swapped) → identical write set.
- **Degenerate, collinear** (10,10), (20,20), (30,30) → zero writes; `done` 3 cycles after `start`.
- **Clamping:**
  - vertices (-5.0, 0.0), (700.0, 0.0), (0.0, 500.0) → no write with x > 639 or y > 479;
  - first write at (0,0).
- **Reset mid-SCAN:** assert `areset` for 1 cycle → `fb_we` and `done` stay 0 thereafter until a new `start`.
- **`start` held high:** second render begins the cycle after `done`, producing an identical write sequence.

Source files
------------

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared GPU constants, rasterizer FSM states and the
// triangle edge-function helper.
package gpu_pkg;

    localparam int COORD_W      = 10;
    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;
    localparam int EDGE_W       = 24;

    typedef logic [COORD_W-1:0]       coord_t;
    typedef logic signed [EDGE_W-1:0] edge_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVERT,
        S_SETUP,
        S_SCAN,
        S_DONE
    } state_t;

    function automatic edge_t zext(input coord_t v);
        return edge_t'({{(EDGE_W-COORD_W){1'b0}}, v});
    endfunction

    // (bx-ax)(py-ay) - (by-ay)(px-ax); every term fits well inside EDGE_W
    function automatic edge_t edge_fn(
        input coord_t ax, input coord_t ay,
        input coord_t bx, input coord_t by,
        input coord_t px, input coord_t py
    );
        edge_t dxb, dyp, dyb, dxp;
        dxb = zext(bx) - zext(ax);
        dyp = zext(py) - zext(ay);
        dyb = zext(by) - zext(ay);
        dxp = zext(px) - zext(ax);
        return (dxb * dyp) - (dyb * dxp);
    endfunction

endpackage

// File: rtl/float_to_coord.sv
// float_to_coord: IEEE-754 single to saturated unsigned screen coordinate.
// Ports: i_f (32-bit float in), o_coord (COORD_W-bit truncated value out).
module float_to_coord
    import gpu_pkg::*;
(
    input  logic [31:0] i_f,
    output coord_t      o_coord
);

    logic        w_sign;
    logic [7:0]  w_exp;
    logic [23:0] w_mant;
    logic [7:0]  w_sh;

    assign w_sign = i_f[31];
    assign w_exp  = i_f[30:23];
    assign w_mant = {1'b1, i_f[22:0]};
    // only meaningful for 127 <= exp <= 136, i.e. shifts of 14..23
    assign w_sh   = 8'd150 - w_exp;

    always_comb begin
        o_coord = '0;
        if (w_sign || (w_exp < 8'd127)) begin
            o_coord = '0;
        end else if (w_exp >= 8'd137) begin
            o_coord = '1;
        end else begin
            o_coord = COORD_W'(w_mant >> w_sh);
        end
    end

endmodule

// File: rtl/rasterizer.sv
// rasterizer: flat-shaded triangle scan, one bounding-box pixel per clock.
// Ports: clk, areset, start, p1..p3 {z,y,x} floats in; done, fb_x, fb_y, data, fb_we out.
module rasterizer
    import gpu_pkg::*;
#(
    parameter logic [3:0] COLOR    = 4'hF,
    parameter int         SCREEN_W = SCREEN_W_DEF,
    parameter int         SCREEN_H = SCREEN_H_DEF
) (
    input  logic               clk,
    input  logic               areset,
    input  logic               start,
    input  logic [2:0][31:0]   p1,
    input  logic [2:0][31:0]   p2,
    input  logic [2:0][31:0]   p3,
    output logic               done,
    output logic [COORD_W-1:0] fb_x,
    output logic [COORD_W-1:0] fb_y,
    output logic [3:0]         data,
    output logic               fb_we
);

    localparam coord_t XLIM = coord_t'(SCREEN_W - 1);
    localparam coord_t YLIM = coord_t'(SCREEN_H - 1);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_fx [3];
    logic [31:0] r_fy [3];
    coord_t      w_cx [3];
    coord_t      w_cy [3];
    coord_t      r_x  [3];
    coord_t      r_y  [3];
    coord_t      r_xmin, r_xmax, r_ymin, r_ymax;
    coord_t      r_px, r_py;
    coord_t      w_xmin, w_xmax, w_ymin, w_ymax;
    edge_t       w_area, w_e12, w_e23, w_e31;
    logic        w_degen, w_cover, w_last;
    logic        w_we_d, w_done_d;
    logic        w_unused_z;

    assign w_unused_z = ^{p1[2], p2[2], p3[2]};

    function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic coord_t clamp(input coord_t v, input coord_t lim);
        return (v > lim) ? lim : v;
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g_cvt
        float_to_coord u_fx (.i_f(r_fx[i]), .o_coord(w_cx[i]));
        float_to_coord u_fy (.i_f(r_fy[i]), .o_coord(w_cy[i]));
    end

    // both ends are clamped so a fully off-screen box collapses onto the edge
    assign w_xmin = clamp(min3(r_x[0], r_x[1], r_x[2]), XLIM);
    assign w_xmax = clamp(max3(r_x[0], r_x[1], r_x[2]), XLIM);
    assign w_ymin = clamp(min3(r_y[0], r_y[1], r_y[2]), YLIM);
    assign w_ymax = clamp(max3(r_y[0], r_y[1], r_y[2]), YLIM);

    assign w_area  = edge_fn(r_x[0], r_y[0], r_x[1], r_y[1], r_x[2], r_y[2]);
    assign w_degen = (w_area == '0);

    assign w_e12 = edge_fn(r_x[0], r_y[0], r_x[1], r_y[1], r_px, r_py);
    assign w_e23 = edge_fn(r_x[1], r_y[1], r_x[2], r_y[2], r_px, r_py);
    assign w_e31 = edge_fn(r_x[2], r_y[2], r_x[0], r_y[0], r_px, r_py);

    // inclusive test for either winding: no negative edge, or no positive edge
    assign w_cover = ((w_e12 >= 0) && (w_e23 >= 0) && (w_e31 >= 0))
                  || ((w_e12 <= 0) && (w_e23 <= 0) && (w_e31 <= 0));

    assign w_last = (r_px == r_xmax) && (r_py == r_ymax);

    always_ff @(posedge clk) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    w_next = start ? S_CONVERT : S_IDLE;
            S_CONVERT: w_next = S_SETUP;
            S_SETUP:   w_next = w_degen ? S_DONE : S_SCAN;
            S_SCAN:    w_next = w_last ? S_DONE : S_SCAN;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_we_d   = (r_state == S_SCAN) && w_cover;
        w_done_d = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && start) begin
            r_fx[0] <= p1[0];
            r_fy[0] <= p1[1];
            r_fx[1] <= p2[0];
            r_fy[1] <= p2[1];
            r_fx[2] <= p3[0];
            r_fy[2] <= p3[1];
        end
        if (r_state == S_CONVERT) begin
            for (int i = 0; i < 3; i++) begin
                r_x[i] <= w_cx[i];
                r_y[i] <= w_cy[i];
            end
        end
        if (r_state == S_SETUP) begin
            r_xmin <= w_xmin;
            r_xmax <= w_xmax;
            r_ymin <= w_ymin;
            r_ymax <= w_ymax;
            r_px   <= w_xmin;
            r_py   <= w_ymin;
        end
        if (r_state == S_SCAN) begin
            if (r_px == r_xmax) begin
                r_px <= r_xmin;
                r_py <= r_py + 1'b1;
            end else begin
                r_px <= r_px + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            done  <= 1'b0;
            fb_we <= 1'b0;
            fb_x  <= '0;
            fb_y  <= '0;
            data  <= '0;
        end else begin
            done  <= w_done_d;
            fb_we <= w_we_d;
            data  <= w_we_d ? COLOR : 4'h0;
            if (w_we_d) begin
                fb_x <= r_px;
                fb_y <= r_py;
            end
        end
    end

endmodule

// File: tb/tb_rasterizer.sv
// tb_rasterizer: scoreboard bench; a reference model queues expected writes,
// a monitor pops and compares them as the rasterizer emits them.
module tb_rasterizer;

    localparam int         SW  = 172;
    localparam int         SH  = 172;
    localparam logic [3:0] COL = 4'hA;

    logic             clk = 1'b0;
    logic             areset;
    logic             start;
    logic [2:0][31:0] p1, p2, p3;
    logic             done, fb_we;
    logic [9:0]       fb_x, fb_y;
    logic [3:0]       data;

    rasterizer #(.COLOR(COL), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clk(clk), .areset(areset), .start(start),
        .p1(p1), .p2(p2), .p3(p3),
        .done(done), .fb_x(fb_x), .fb_y(fb_y),
        .data(data), .fb_we(fb_we)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_done;
        logic [9:0] x;
        logic [9:0] y;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    bit  mon_en = 1'b0;
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  wr_cnt = 0;
    int  first_x, first_y, max_x, max_y;
    bit  seen[int];
    bit  ref_set[int];
    int  vq[6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // vertex value is q/4, exactly representable
    function automatic logic [31:0] enc(input int q);
        logic [31:0] a, m;
        int n;
        if (q == 0) return 32'h0;
        a = (q < 0) ? -q : q;
        n = 31;
        while (a[n] == 1'b0) n--;
        m = a << (23 - n);
        return {(q < 0), 8'(127 + n - 2), m[22:0]};
    endfunction

    function automatic int cvt(input int q);
        if (q < 0) return 0;
        return (q / 4 > 1023) ? 1023 : q / 4;
    endfunction

    function automatic int edgef(input int ax, ay, bx, by, px, py);
        return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
    endfunction

    function automatic int mn(input int a, b);
        return (a < b) ? a : b;
    endfunction

    function automatic int mx(input int a, b);
        return (a > b) ? a : b;
    endfunction

    task automatic build_model(output int n_scan);
        int c[6];
        int x0, x1, y0, y1, e1, e2, e3;
        for (int i = 0; i < 6; i++) c[i] = cvt(vq[i]);
        x0 = mn(mn(mn(c[0], c[2]), c[4]), SW - 1);
        x1 = mn(mx(mx(c[0], c[2]), c[4]), SW - 1);
        y0 = mn(mn(mn(c[1], c[3]), c[5]), SH - 1);
        y1 = mn(mx(mx(c[1], c[3]), c[5]), SH - 1);
        n_scan = 0;
        if (edgef(c[0], c[1], c[2], c[3], c[4], c[5]) != 0) begin
            n_scan = (x1 - x0 + 1) * (y1 - y0 + 1);
            for (int y = y0; y <= y1; y++)
                for (int x = x0; x <= x1; x++) begin
                    e1 = edgef(c[0], c[1], c[2], c[3], x, y);
                    e2 = edgef(c[2], c[3], c[4], c[5], x, y);
                    e3 = edgef(c[4], c[5], c[0], c[1], x, y);
                    if ((e1 >= 0 && e2 >= 0 && e3 >= 0) ||
                        (e1 <= 0 && e2 <= 0 && e3 <= 0))
                        exp_q.push_back('{is_done: 1'b0, x: 10'(x), y: 10'(y)});
                end
        end
        exp_q.push_back('{is_done: 1'b1, x: 10'd0, y: 10'd0});
    endtask

    task automatic set_verts();
        p1 = {32'($urandom), enc(vq[1]), enc(vq[0])};
        p2 = {32'($urandom), enc(vq[3]), enc(vq[2])};
        p3 = {32'($urandom), enc(vq[5]), enc(vq[4])};
    endtask

    task automatic clr_stats();
        wr_cnt = 0;
        first_x = -1;
        first_y = -1;
        max_x = 0;
        max_y = 0;
        seen.delete();
    endtask

    task automatic set_tri(input int a, b, c, d, e, f);
        vq[0] = a; vq[1] = b; vq[2] = c; vq[3] = d; vq[4] = e; vq[5] = f;
    endtask

    task automatic wait_done(input int n, input int c0);
        int d0, k;
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < n + 40) begin
            @(negedge clk); #1;
            k++;
        end
        if (done_cnt == d0) begin
            chk("done_timeout", done_cnt, d0 + 1);
            exp_q.delete();
        end else begin
            chk("done_latency", done_cyc - c0, 4 + n);
        end
    endtask

    task automatic run_one();
        int n, c0;
        clr_stats();
        build_model(n);
        set_verts();
        start = 1'b1;
        c0 = cyc;
        @(negedge clk); #1;
        start = 1'b0;
        wait_done(n, c0);
    endtask

    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (fb_we) begin
                    chk("wr_data", 32'(data), 32'(COL));
                    if (exp_q.size() == 0) begin
                        chk("wr_unexpected_x", 32'(fb_x), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_is_pixel", 32'(e.is_done), 32'd0);
                        chk("wr_x", 32'(fb_x), 32'(e.x));
                        chk("wr_y", 32'(fb_y), 32'(e.y));
                    end
                    if (first_x < 0) begin
                        first_x = int'(fb_x);
                        first_y = int'(fb_y);
                    end
                    max_x = mx(max_x, int'(fb_x));
                    max_y = mx(max_y, int'(fb_y));
                    seen[int'(fb_y) * 1024 + int'(fb_x)] = 1'b1;
                    wr_cnt++;
                end else begin
                    chk("idle_data", 32'(data), 32'd0);
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("done_unexpected", 32'(done), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_order", 32'(e.is_done), 32'd1);
                    end
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    initial begin : driver
        int n, c0, diffs;
        areset = 1'b1;
        start = 1'b0;
        p1 = '0; p2 = '0; p3 = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(fb_we), 32'd0);
        chk("rst_x", 32'(fb_x), 32'd0);
        chk("rst_y", 32'(fb_y), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        areset = 1'b0;
        @(negedge clk); #1;
        mon_en = 1'b1;

        set_tri(276, 276, 276, 676, 676, 276);
        run_one();
        chk("rt_count", wr_cnt, 5151);
        chk("rt_69_69", 32'(seen.exists(69 * 1024 + 69)), 1);
        chk("rt_119_119", 32'(seen.exists(119 * 1024 + 119)), 1);
        chk("rt_120_120", 32'(seen.exists(120 * 1024 + 120)), 0);
        chk("rt_169_169", 32'(seen.exists(169 * 1024 + 169)), 0);
        ref_set = seen;

        set_tri(276, 276, 676, 276, 276, 676);
        run_one();
        diffs = 0;
        foreach (ref_set[k]) if (!seen.exists(k)) diffs++;
        chk("wind_count", wr_cnt, ref_set.size());
        chk("wind_diffs", diffs, 0);

        set_tri(40, 40, 80, 80, 120, 120);
        run_one();
        chk("degen_writes", wr_cnt, 0);

        set_tri(-20, 0, 2800, 0, 0, 2000);
        run_one();
        chk("clamp_first_x", first_x, 0);
        chk("clamp_first_y", first_y, 0);
        chk("clamp_x_in", 32'(max_x <= SW - 1), 1);
        chk("clamp_y_in", 32'(max_y <= SH - 1), 1);

        set_tri(8000, 680, 680, 8000, 680, 680);
        run_one();
        chk("sat_writes", wr_cnt, 4);

        for (int t = 0; t < 14; t++) begin
            for (int i = 0; i < 6; i++) vq[i] = int'($urandom_range(0, 192)) - 32;
            run_one();
        end

        set_tri(20, 20, 100, 30, 50, 90);
        clr_stats();
        build_model(n);
        build_model(n);
        set_verts();
        start = 1'b1;
        c0 = cyc;
        wait_done(n, c0);
        c0 = done_cyc;
        @(negedge clk); #1;
        start = 1'b0;
        wait_done(n, c0);

        mon_en = 1'b0;
        exp_q.delete();
        set_tri(276, 276, 276, 676, 676, 276);
        set_verts();
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (300) @(negedge clk);
        #1;
        areset = 1'b1;
        @(negedge clk); #1;
        areset = 1'b0;
        chk("rst_mid_x", 32'(fb_x), 32'd0);
        chk("rst_mid_data", 32'(data), 32'd0);
        for (int i = 0; i < 60; i++) begin
            chk("rst_mid_we", 32'(fb_we), 32'd0);
            chk("rst_mid_done", 32'(done), 32'd0);
            @(negedge clk); #1;
        end
        mon_en = 1'b1;

        set_tri(0, 0, 40, 0, 0, 40);
        run_one();

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
